// File: rtl/seq_scan_ctrl.sv
// Serial pattern-scan controller: serialises parallel words MSB-first, matches a
// runtime-programmed bit pattern (overlapping) and counts hits with a sticky IRQ.
module seq_scan_ctrl #(
    parameter int WORD_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    output logic               ser_valid,
    output logic               ser_bit,
    output logic               det_hit,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               irq,
    input  logic               irq_clr,
    output logic               busy
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WORD_W-1:0]  sreg_r;
    logic [IDX_W-1:0]   idx_r;
    logic [PAT_MAX-1:0] hist_r, hist_s, pat_r;
    logic [LEN_W-1:0]   seen_r, seen_s, len_r, len_s;
    logic [CNT_W-1:0]   thresh_r, cnt_r, cnt_s;
    logic               ser_valid_r, busy_r, det_r, irq_r;
    logic               shifting_s, last_s, accept_s, hist_clr_s, match_s, irq_set_s;

    // Low len bits of history must equal the pattern once enough bits have been seen.
    function automatic logic pat_match(input logic [PAT_MAX-1:0] hist,
                                       input logic [PAT_MAX-1:0] pat,
                                       input logic [LEN_W-1:0]   seen,
                                       input logic [LEN_W-1:0]   len);
        logic [PAT_MAX-1:0] mask;
        mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        return (len != '0) && (seen >= len) && (((hist ^ pat) & mask) == '0);
    endfunction

    assign shifting_s = (state_r == ST_SHIFT);
    assign last_s     = shifting_s && (idx_r == LAST_IDX);
    assign in_ready   = (state_r == ST_WAIT) || (last_s && en);
    assign accept_s   = in_valid && in_ready;
    assign hist_clr_s = (state_r == ST_IDLE) && (en || cfg_we);

    assign ser_valid  = ser_valid_r;
    assign ser_bit    = sreg_r[WORD_W-1];
    assign det_hit    = det_r;
    assign match_cnt  = cnt_r;
    assign irq        = irq_r;
    assign busy       = busy_r;

    // Next-state logic of the word sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) state_s = ST_WAIT;
                else    state_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (accept_s) state_s = ST_SHIFT;
                else          state_s = ST_WAIT;
            end
            ST_SHIFT: begin
                if (!last_s)       state_s = ST_SHIFT;
                else if (accept_s) state_s = ST_SHIFT;
                else if (en)       state_s = ST_WAIT;
                else               state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // History update, match detection, counter increment and config clamp.
    always_comb begin
        hist_s = hist_r;
        seen_s = seen_r;
        if (hist_clr_s) begin
            hist_s = '0;
            seen_s = '0;
        end else if (shifting_s) begin
            hist_s = {hist_r[PAT_MAX-2:0], sreg_r[WORD_W-1]};
            if (seen_r != LEN_MAX) seen_s = seen_r + LEN_W'(1);
            else                   seen_s = seen_r;
        end else begin
            hist_s = hist_r;
            seen_s = seen_r;
        end
        match_s = shifting_s && pat_match(hist_s, pat_r, seen_s, len_r);
        if (cnt_r != '1) cnt_s = cnt_r + CNT_W'(1);
        else             cnt_s = cnt_r;
        irq_set_s = match_s && (thresh_r != '0) && (cnt_s == thresh_r);
        if (cfg_len > LEN_MAX) len_s = LEN_MAX;
        else                   len_s = cfg_len;
    end

    // Sequencer state, serialiser and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            sreg_r      <= '0;
            idx_r       <= '0;
            ser_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ser_valid_r <= (state_s == ST_SHIFT);
            busy_r      <= (state_s != ST_IDLE);
            if (accept_s) begin
                sreg_r <= in_data;
                idx_r  <= '0;
            end else if (shifting_s) begin
                sreg_r <= {sreg_r[WORD_W-2:0], 1'b0};
                idx_r  <= idx_r + IDX_W'(1);
            end
        end
    end

    // Config, bit history, match counter and sticky IRQ; a set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r    <= '0;
            len_r    <= '0;
            thresh_r <= '0;
            hist_r   <= '0;
            seen_r   <= '0;
            det_r    <= 1'b0;
            cnt_r    <= '0;
            irq_r    <= 1'b0;
        end else begin
            if (cfg_we && (state_r == ST_IDLE)) begin
                pat_r    <= cfg_pat;
                len_r    <= len_s;
                thresh_r <= cfg_thresh;
            end
            hist_r <= hist_s;
            seen_r <= seen_s;
            det_r  <= match_s;
            if (match_s) cnt_r <= cnt_s;
            if (irq_set_s)    irq_r <= 1'b1;
            else if (irq_clr) irq_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: a queue-based stream model checked every
// cycle against a default instance and a CNT_W=2 instance, plus literal spot checks.
module tb_seq_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst, en, cfg_we, in_valid, irq_clr;
    logic [7:0] cfg_pat, cfg_thresh, in_data;
    logic [3:0] cfg_len;
    logic       in_ready, ser_valid, ser_bit, det_hit, irq, busy;
    logic [7:0] match_cnt;
    logic       in_ready2, ser_valid2, ser_bit2, det_hit2, irq2, busy2;
    logic [1:0] match_cnt2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
        .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .ser_valid(ser_valid),
        .ser_bit(ser_bit), .det_hit(det_hit), .match_cnt(match_cnt), .irq(irq),
        .irq_clr(irq_clr), .busy(busy)
    );

    seq_scan_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
        .cfg_len(cfg_len), .cfg_thresh(cfg_thresh[1:0]), .in_valid(in_valid),
        .in_ready(in_ready2), .in_data(in_data), .ser_valid(ser_valid2),
        .ser_bit(ser_bit2), .det_hit(det_hit2), .match_cnt(match_cnt2), .irq(irq2),
        .irq_clr(irq_clr), .busy(busy2)
    );

    // Model: pending serial bits and the full seen-bit history as queues.
    bit         q_bits[$];
    bit         hq[$];
    bit         m_init = 1'b0;
    bit         m_active, m_det, m_irq, m_irq2;
    logic [7:0] m_pat, m_thresh;
    int         m_len, m_cnt, m_cnt2;

    function automatic bit m_match();
        if (m_len == 0 || hq.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (hq[hq.size() - 1 - i] != m_pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        int qs;
        bit hs, b, was_active;
        if (rst) begin
            q_bits.delete(); hq.delete();
            m_init = 1'b1; m_active = 1'b0; m_det = 1'b0;
            m_irq = 1'b0; m_irq2 = 1'b0;
            m_pat = 8'd0; m_thresh = 8'd0; m_len = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            qs = q_bits.size();
            was_active = m_active;
            hs = m_active && (qs == 0 || (qs == 1 && en)) && in_valid;
            m_det = 1'b0;
            if (qs > 0) begin
                b = q_bits.pop_front();
                hq.push_back(b);
                if (hq.size() > 16) void'(hq.pop_front());
                m_det = m_match();
            end
            if (m_det) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (m_det && m_thresh != 8'd0 && m_cnt == int'(m_thresh)) m_irq = 1'b1;
            else if (irq_clr) m_irq = 1'b0;
            if (m_det && m_thresh[1:0] != 2'd0 && m_cnt2 == int'(m_thresh[1:0])) m_irq2 = 1'b1;
            else if (irq_clr) m_irq2 = 1'b0;
            if (hs) for (int i = 7; i >= 0; i--) q_bits.push_back(in_data[i]);
            if (!was_active) begin
                if (cfg_we) begin
                    m_pat = cfg_pat; m_thresh = cfg_thresh;
                    m_len = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
                    hq.delete();
                end
                if (en) begin
                    m_active = 1'b1;
                    hq.delete();
                end
            end else if (qs == 1 && !hs && !en) begin
                m_active = 1'b0;
            end
        end
    end

    // Observed stream statistics (bench-side, from DUT outputs).
    int hit_pos[$];
    int sv_total = 0, cur_run = 0, last_run = 0, sv_base = 0, hit_base = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        bit exp_ready;
        if (m_init) begin
            exp_ready = m_active && (q_bits.size() == 0 || (q_bits.size() == 1 && en));
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("ser_valid", 32'(ser_valid), 32'(q_bits.size() > 0));
            if (q_bits.size() > 0) chk("ser_bit", 32'(ser_bit), 32'(q_bits[0]));
            chk("det_hit", 32'(det_hit), 32'(m_det));
            chk("match_cnt", 32'(match_cnt), m_cnt);
            chk("irq", 32'(irq), 32'(m_irq));
            chk("busy", 32'(busy), 32'(m_active));
            chk("in_ready2", 32'(in_ready2), 32'(exp_ready));
            chk("ser_valid2", 32'(ser_valid2), 32'(q_bits.size() > 0));
            if (q_bits.size() > 0) chk("ser_bit2", 32'(ser_bit2), 32'(q_bits[0]));
            chk("det_hit2", 32'(det_hit2), 32'(m_det));
            chk("match_cnt2", 32'(match_cnt2), m_cnt2);
            chk("irq2", 32'(irq2), 32'(m_irq2));
            chk("busy2", 32'(busy2), 32'(m_active));
        end
        if (det_hit === 1'b1) hit_pos.push_back(sv_total);
        if (ser_valid === 1'b1) begin
            sv_total++;
            cur_run++;
        end else begin
            if (cur_run > 0) last_run = cur_run;
            cur_run = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        hit_base = hit_pos.size();
        sv_base  = sv_total;
    endtask

    function automatic int hp(input int k);
        if (hit_base + k < hit_pos.size()) return hit_pos[hit_base + k] - sv_base;
        return -1;
    endfunction

    function automatic int nhits();
        return hit_pos.size() - hit_base;
    endfunction

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
        cfg_pat = p; cfg_len = l; cfg_thresh = t; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    // Returns in the cycle carrying the first serial bit of the word.
    task automatic send(input logic [7:0] d);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        for (int k = 0; k < 40 && !done; k++) begin
            if (in_ready) done = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("handshake", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; irq_clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_pat = 8'd0; cfg_len = 4'd0;
        cfg_thresh = 8'd0; in_valid = 1'b0; in_data = 8'd0; irq_clr = 1'b0;
        step(); step();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("rst_ser_bit", 32'(ser_bit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        rst = 1'b0;

        // Pattern 1010 over 0xAA: hits after bits 4, 6, 8.
        cfg(8'h0A, 4'd4, 8'd0); mark(); en = 1'b1; send(8'hAA); en = 1'b0;
        repeat (12) step();
        chk("t1_hits", nhits(), 32'd3);
        chk("t1_pos0", hp(0), 32'd4);
        chk("t1_pos1", hp(1), 32'd6);
        chk("t1_pos2", hp(2), 32'd8);
        chk("t1_cnt", 32'(match_cnt), 32'd3);
        chk("t1_idle", 32'(busy), 32'd0);

        // Back-to-back 0x0F words: 16-bit unbroken stream, 1111 completes at each word end.
        do_reset(); cfg(8'h0F, 4'd4, 8'd0); mark(); en = 1'b1;
        send(8'h0F); send(8'h0F); en = 1'b0;
        repeat (12) step();
        chk("t2_run", last_run, 32'd16);
        chk("t2_hits", nhits(), 32'd2);
        chk("t2_pos0", hp(0), 32'd8);
        chk("t2_pos1", hp(1), 32'd16);

        // Threshold 2 with pattern 10; clear coincides with the setting edge.
        do_reset(); cfg(8'h02, 4'd2, 8'd2); en = 1'b1; send(8'hAA); en = 1'b0;
        step(); step(); step();
        irq_clr = 1'b1; step(); irq_clr = 1'b0;
        chk("t3_det", 32'(det_hit), 32'd1);
        chk("t3_irq_set_wins", 32'(irq), 32'd1);
        chk("t3_cnt2", 32'(match_cnt), 32'd2);
        repeat (10) step();
        chk("t3_cnt_end", 32'(match_cnt), 32'd4);
        chk("t3_irq_sticky", 32'(irq), 32'd1);
        irq_clr = 1'b1; step(); irq_clr = 1'b0;
        chk("t3_irq_clr", 32'(irq), 32'd0);

        // Single-bit pattern over 0xFF: 8 pulses, narrow counter saturates at 3.
        do_reset(); cfg(8'h01, 4'd1, 8'd0); mark(); en = 1'b1; send(8'hFF); en = 1'b0;
        repeat (12) step();
        chk("t4_hits", nhits(), 32'd8);
        chk("t4_cnt", 32'(match_cnt), 32'd8);
        chk("t4_cnt_sat", 32'(match_cnt2), 32'd3);

        // Config write while busy is dropped; en low mid-word still finishes the word.
        do_reset(); cfg(8'h0A, 4'd4, 8'd0); mark(); en = 1'b1; send(8'hAA); en = 1'b0;
        cfg_pat = 8'h0F; cfg_len = 4'd4; cfg_we = 1'b1; step(); cfg_we = 1'b0;
        repeat (12) step();
        chk("t5_hits", nhits(), 32'd3);
        chk("t5_pos2", hp(2), 32'd8);
        chk("t5_idle", 32'(busy), 32'd0);
        mark(); en = 1'b1; send(8'h0F); en = 1'b0;
        repeat (12) step();
        chk("t5_old_pat", nhits(), 32'd0);

        // Reset at bit 3 of a word, after one hit has raised irq.
        do_reset(); cfg(8'h02, 4'd2, 8'd1); en = 1'b1; send(8'hAA);
        step(); step();
        chk("t6_pre_irq", 32'(irq), 32'd1);
        rst = 1'b1; step();
        chk("t6_ser_valid", 32'(ser_valid), 32'd0);
        chk("t6_ser_bit", 32'(ser_bit), 32'd0);
        chk("t6_det", 32'(det_hit), 32'd0);
        chk("t6_irq", 32'(irq), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(in_ready), 32'd0);
        chk("t6_cnt", 32'(match_cnt), 32'd0);
        rst = 1'b0; en = 1'b0; step();

        // Length above PAT_MAX clamps to 8: full-word match only at bit 8.
        do_reset(); cfg(8'hAA, 4'd15, 8'd0); mark(); en = 1'b1; send(8'hAA); en = 1'b0;
        repeat (12) step();
        chk("t7_hits", nhits(), 32'd1);
        chk("t7_pos", hp(0), 32'd8);

        // Length 0 disables detection.
        cfg(8'h00, 4'd0, 8'd0); mark(); en = 1'b1; send(8'h00); en = 1'b0;
        repeat (12) step();
        chk("t8_off", nhits(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
